// File: rtl/bin2csd_seq_pkg.sv
// Shared definitions for the binary-to-CSD recoder: FSM states and digit codes.
// csd2bin uses the same digit codes, so both blocks import them from here.
package bin2csd_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CONV = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // 2'b11 is never produced.
  localparam logic [1:0] CSD_0  = 2'b00;
  localparam logic [1:0] CSD_P1 = 2'b01;
  localparam logic [1:0] CSD_M1 = 2'b10;

endpackage

// File: rtl/bin2csd_seq_csd_digit.sv
// One step of the Reitwiesner recurrence. It is purely combinational so that a
// parallel recoder can later chain W copies of it.
//   cout  = (b0 + b1 + cin) >= 2
//   digit = b0 + cin - 2*cout
module csd_digit
  import bin2csd_seq_pkg::*;
(
  input  logic       b0,
  input  logic       b1,
  input  logic       cin,
  output logic [1:0] digit,
  output logic       cout
);

  // Majority carry. When b0 and cin differ, the digit is -1 if the carry
  // propagates through b1 and +1 otherwise.
  always_comb begin
    cout  = (b0 & b1) | (b0 & cin) | (b1 & cin);
    digit = CSD_0;
    if (b0 ^ cin) begin
      digit = b1 ? CSD_M1 : CSD_P1;
    end
  end

endmodule

// File: rtl/bin2csd_seq.sv
// Sequential binary-to-CSD recoder. It emits one digit per clock, LSB first,
// shifting each digit into the top of y. After W steps y holds the full word.
//
// state   | meaning
// --------+-------------------------------------------------------------
// ST_IDLE | ready for an operand; x is loaded on in_valid
// ST_CONV | one digit per cycle, W cycles in total
// ST_DONE | y is complete and held until out_ready
module bin2csd_seq
  import bin2csd_seq_pkg::*;
#(
  parameter  int W  = 5,
  localparam int CW = (W > 1) ? $clog2(W) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [W-1:0]   x,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*W-1:0] y
);

  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  state_t          r_state;
  state_t          w_state_next;
  logic [W-1:0]    r_sh;
  logic            r_carry;
  logic [CW-1:0]   r_cnt;
  logic [2*W-1:0]  r_y;

  logic            w_load;
  logic            w_step;
  logic            w_b1;
  logic [1:0]      w_digit;
  logic            w_cout;

  // On the last step sh[1] would be out of range for small W, so the sign bit
  // is taken directly. With sign fill it has the same value anyway.
  assign w_b1 = (r_cnt == CNT_LAST) ? r_sh[W-1] : r_sh[1];

  csd_digit u_digit (
    .b0    (r_sh[0]),
    .b1    (w_b1),
    .cin   (r_carry),
    .digit (w_digit),
    .cout  (w_cout)
  );

  // Next-state and handshake outputs.
  always_comb begin
    w_state_next = r_state;
    w_load       = 1'b0;
    w_step       = 1'b0;
    in_ready     = 1'b0;
    out_valid    = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_load       = 1'b1;
          w_state_next = ST_CONV;
        end
      end
      ST_CONV: begin
        w_step = 1'b1;
        if (r_cnt == CNT_LAST) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath: load the operand, then shift one digit in per CONV cycle.
  // The carry out of the top digit is dropped; W digits always cover the range.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sh    <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_y     <= '0;
    end else if (w_load) begin
      r_sh    <= x;
      r_carry <= 1'b0;
      r_cnt   <= '0;
    end else if (w_step) begin
      r_y     <= {w_digit, r_y[2*W-1:2]};
      r_sh    <= {r_sh[W-1], r_sh[W-1:1]};
      r_carry <= w_cout;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

  assign y = r_y;

endmodule

// File: tb/tb_bin2csd_seq.sv
// Bench for bin2csd_seq. The driver pushes the expected CSD word when an
// operand is accepted, and the monitor pops and checks it on each output
// handshake. The reference recoding is the non-adjacent form computed with
// plain integer arithmetic.
module tb_bin2csd_seq;
  localparam int W = 5;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   x;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] y;

  int n_chk  = 0;
  int n_pass = 0;
  bit bp_rand = 1'b0;
  bit or_force = 1'b1;

  logic [2*W-1:0] exp_q[$];
  int             x_q[$];

  bin2csd_seq #(.W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .x         (x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .y         (y)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
  endtask

  // Non-adjacent form: odd remainders pick +1 or -1 so that the rest is
  // divisible by 4, which forces the next digit to zero.
  function automatic logic [2*W-1:0] ref_csd(input int v);
    int r = v;
    int m;
    logic [2*W-1:0] res = '0;
    for (int i = 0; i < W; i++) begin
      m = ((r % 4) + 4) % 4;
      if (m == 1) begin
        res[2*i +: 2] = 2'b01;
        r = r - 1;
      end else if (m == 3) begin
        res[2*i +: 2] = 2'b10;
        r = r + 1;
      end
      r = r / 2;
    end
    return res;
  endfunction

  // Decoder: the value that csd2bin would produce for a word.
  function automatic int csd_value(input logic [2*W-1:0] w);
    int s = 0;
    for (int i = 0; i < W; i++) begin
      if (w[2*i +: 2] == 2'b01) s += (1 << i);
      else if (w[2*i +: 2] == 2'b10) s -= (1 << i);
    end
    return s;
  endfunction

  function automatic int bad_digits(input logic [2*W-1:0] w);
    int n = 0;
    for (int i = 0; i < W; i++)
      if (w[2*i +: 2] == 2'b11) n++;
    return n;
  endfunction

  function automatic int adjacent_nz(input logic [2*W-1:0] w);
    int n = 0;
    for (int i = 0; i < W - 1; i++)
      if (w[2*i +: 2] != 2'b00 && w[2*i+2 +: 2] != 2'b00) n++;
    return n;
  endfunction

  // out_ready changes only just after a rising edge.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_rand ? 1'($urandom_range(0, 1)) : or_force;
    end
  end

  // Monitor: on each output handshake, pop the expected word and check it.
  initial begin
    logic [2*W-1:0] e;
    int xv;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_output", 1, 0);
        end else begin
          e  = exp_q.pop_front();
          xv = x_q.pop_front();
          chk("y_word", longint'(y), longint'(e));
          chk("csd2bin_roundtrip", csd_value(y), xv);
          chk("no_11_digit", bad_digits(y), 0);
          chk("no_adjacent_nz", adjacent_nz(y), 0);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] v, input logic [2*W-1:0] e);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", 0, 1);
      return;
    end
    in_valid = 1'b1;
    x = v;
    exp_q.push_back(e);
    x_q.push_back(int'($signed(v)));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    x = W'($urandom);
  endtask

  task automatic send_ref(input logic [W-1:0] v);
    send(v, ref_csd(int'($signed(v))));
  endtask

  task automatic drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 1000) begin
      @(posedge clk);
      n++;
    end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  initial begin
    logic [2*W-1:0] yhold;
    int n;
    rst = 1'b1;
    in_valid = 1'b0;
    x = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_y", y, 0);
    rst = 1'b0;

    // 15 and latency: out_valid rises W edges after the accept edge.
    send(5'b01111, 10'b01_00_00_00_10);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!out_valid && n < 50);
    chk("latency", n, W);
    drain();

    send(5'b11111, 10'b00_00_00_00_10);
    send(5'b10000, 10'b10_00_00_00_00);
    send(5'b01011, 10'b01_00_10_00_10);
    drain();

    // Backpressure: hold out_ready low and pulse in_valid while DONE.
    or_force = 1'b0;
    @(posedge clk);
    #2;
    send_ref(5'b00110);
    n = 0;
    while (!out_valid && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("bp_reach_done", out_valid, 1);
    yhold = y;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("bp_y_stable", y, yhold);
      chk("bp_in_ready_low", in_ready, 0);
      chk("bp_out_valid_held", out_valid, 1);
      if (k == 0) begin
        in_valid = 1'b1;
        x = 5'b01010;
      end else begin
        in_valid = 1'b0;
      end
    end
    or_force = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("bp_idle_in_ready", in_ready, 1);
    chk("bp_idle_out_valid", out_valid, 0);
    chk("bp_consumed", exp_q.size(), 0);

    // Reset during the third CONV cycle aborts the conversion.
    send_ref(5'b10101);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(exp_q.pop_back());
    void'(x_q.pop_back());
    chk("abort_out_valid", out_valid, 0);
    chk("abort_in_ready", in_ready, 1);
    chk("abort_y", y, 0);
    send(5'b00011, 10'b00_00_01_00_10);
    drain();

    // All operands back to back with random out_ready, then random ones.
    bp_rand = 1'b1;
    for (int v = 0; v < (1 << W); v++) send_ref(W'(v));
    for (int i = 0; i < 20; i++) send_ref(W'($urandom));
    drain();
    bp_rand = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
